// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and one-cycle status pulses out.
// master = receiver side, slave = consumer side (which also drives the line).
interface uart_rx_if;
  logic       iRx;
  logic [7:0] oData;
  logic       oData_Valid;
  logic       oFrame_Err;
  logic       oBreak;
  logic       oParity_Err;
  logic       oBusy;

  modport master (
    input  iRx,
    output oData, oData_Valid, oFrame_Err, oBreak, oParity_Err, oBusy
  );

  modport slave (
    output iRx,
    input  oData, oData_Valid, oFrame_Err, oBreak, oParity_Err, oBusy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with majority-vote sampling; parity bit added when UART_RX_PARITY_EN is defined.
// Valid pulse 9*pClksPerBit+H+4 clocks after the start edge (+pClksPerBit with parity); no backpressure, capture on the pulse.
module uart_rx #(
  parameter int pClksPerBit = 868,
  parameter int pParityOdd  = 0
) (
  input  logic      iClk,
  input  logic      iRst_n,
  uart_rx_if.master bus
);
  localparam int H  = pClksPerBit / 2;
  localparam int CW = $clog2(pClksPerBit);
  localparam logic [CW-1:0] CNT_LAST = CW'(pClksPerBit - 1);
  localparam logic [CW-1:0] CNT_LO   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);

  generate
    if (pClksPerBit < 8 || pParityOdd < 0 || pParityOdd > 1) begin : g_bad_param
      $error("uart_rx: pClksPerBit must be >= 8 and pParityOdd 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt_q;
  logic          smp_lo, smp_mid;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q, ferr_q, brk_q, perr_q;
  logic          par_err_q;
  logic          bit_end, dec_tick, decision;
  logic          set_valid, set_ferr, set_brk, set_perr;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign dec_tick = (cnt_q == CNT_DEC);
  assign decision = (smp_lo & smp_mid) | (smp_lo & rx_s) | (smp_mid & rx_s);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    set_valid = 1'b0;
    set_ferr  = 1'b0;
    set_brk   = 1'b0;
    set_perr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (dec_tick && decision) state_d = IDLE;
        else if (bit_end)         state_d = DATA;
      end
      DATA: begin
        if (bit_end && idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (dec_tick) begin
          // Leave at the stop-bit centre so a back-to-back start edge is caught.
          if (decision) begin
            set_valid = !par_err_q;
            set_perr  = par_err_q;
            state_d   = IDLE;
          end else begin
            set_ferr = 1'b1;
            set_brk  = (shift_q == 8'h00);
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      cnt_q   <= '0;
      smp_lo  <= 1'b1;
      smp_mid <= 1'b1;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      rx_meta <= bus.iRx;
      rx_s    <= rx_meta;

      if (state_q == IDLE || bit_end) cnt_q <= '0;
      else                            cnt_q <= cnt_q + 1'b1;

      if (cnt_q == CNT_LO)  smp_lo  <= rx_s;
      if (cnt_q == CNT_MID) smp_mid <= rx_s;

      if (state_q != DATA) idx_q <= '0;
      else if (bit_end)    idx_q <= idx_q + 3'd1;

      if (state_q == DATA && dec_tick) shift_q <= {decision, shift_q[7:1]};

      if (set_valid) data_q <= shift_q;
      valid_q <= set_valid;
      ferr_q  <= set_ferr;
      brk_q   <= set_brk;
      perr_q  <= set_perr;
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (pParityOdd != 0);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      par_err_q <= 1'b0;
    end else if (state_q == IDLE) begin
      par_err_q <= 1'b0;
    end else if (state_q == PARITY && dec_tick) begin
      par_err_q <= (decision != ((^shift_q) ^ PAR_ODD));
    end
  end
`else
  assign par_err_q = 1'b0;
`endif

  assign bus.oData       = data_q;
  assign bus.oData_Valid = valid_q;
  assign bus.oFrame_Err  = ferr_q;
  assign bus.oBreak      = brk_q;
  assign bus.oParity_Err = perr_q;
  assign bus.oBusy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed UART frames; expected pulses queued at stimulus time, popped by a monitor on every DUT pulse.
module tb_uart_rx;
  localparam int N = 16;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 10 * N + H + 4;
`else
  localparam int LAT = 9 * N + H + 4;
`endif

  // flags = {valid, frame_err, break, parity_err}
  localparam logic [3:0] F_VALID = 4'b1000;
  localparam logic [3:0] F_FERR  = 4'b0100;
  localparam logic [3:0] F_BRK   = 4'b0110;
  localparam logic [3:0] F_PERR  = 4'b0001;

  typedef struct {
    logic [3:0] flags;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic iClk = 1'b0;
  logic iRst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  uart_rx_if u_if ();

  uart_rx #(
    .pClksPerBit(N),
    .pParityOdd (0)
  ) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .bus   (u_if.master)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input logic [3:0] flags, input logic [7:0] data, input int at_cyc);
    exp_t e;
    e.flags = flags;
    e.data  = data;
    e.cyc   = at_cyc;
    sb.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    u_if.iRx = b;
    repeat (N) @(negedge iClk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`else
    if (par_b === 1'bx) u_if.iRx = 1'b0;
`endif
    send_bit(stop_b);
  endtask

  // Good frame: expected valid pulse at LAT clocks after the first edge sampling the start bit.
  task automatic send_byte(input logic [7:0] d);
    expect_evt(F_VALID, d, cyc + 1 + LAT);
    send_frame(d, 1'b1, ^d);
  endtask

  task automatic idle_bits(input int n);
    u_if.iRx = 1'b1;
    repeat (n * N) @(negedge iClk);
  endtask

  // Monitor: every cycle with any pulse must match the head of the scoreboard.
  always @(negedge iClk) begin
    logic [3:0] f;
    exp_t e;
    f = {u_if.oData_Valid, u_if.oFrame_Err, u_if.oBreak, u_if.oParity_Err};
    if (iRst_n && f != 4'b0000) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got flags %b expected none (cycle %0d)", f, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_flags", int'(f), int'(e.flags));
        check("data_at_pulse", int'(u_if.oData), int'(e.data));
        if (e.flags == F_VALID) check("busy_at_valid", int'(u_if.oBusy), 0);
        if (e.cyc >= 0) begin
          checks++;
          if (cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
            errors++;
            $display("FAIL latency: got cycle %0d expected %0d +/-1", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int busy_cnt;
    int wait_cnt;

    iRst_n   = 1'b0;
    u_if.iRx = 1'b1;
    repeat (4) @(negedge iClk);
    check("reset_data", int'(u_if.oData), 0);
    check("reset_busy", int'(u_if.oBusy), 0);
    check("reset_pulses", int'({u_if.oData_Valid, u_if.oFrame_Err, u_if.oBreak, u_if.oParity_Err}), 0);
    iRst_n = 1'b1;
    repeat (4) @(negedge iClk);

    // Single good byte with latency and busy checks.
    send_byte(8'h41);
    idle_bits(2);

    // Glitch of 3 clocks: short busy, no pulse.
    u_if.iRx = 1'b0;
    repeat (3) @(negedge iClk);
    u_if.iRx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge iClk);
      if (u_if.oBusy) busy_cnt++;
    end
    check("glitch_busy_seen", int'(busy_cnt > 0), 1);
    check("glitch_busy_short", int'(busy_cnt < N), 1);
    check("glitch_busy_cleared", int'(u_if.oBusy), 0);

    // Framing error keeps the previous byte, then recovery.
    expect_evt(F_FERR, 8'h41, -1);
    send_frame(8'h55, 1'b0, 1'b0);
    idle_bits(2);
    send_byte(8'hA5);
    idle_bits(2);

    // Line held low for 12 bit times: one frame error with break.
    expect_evt(F_BRK, 8'hA5, -1);
    u_if.iRx = 1'b0;
    repeat (12 * N) @(negedge iClk);
    idle_bits(2);
    send_byte(8'h3C);
    idle_bits(2);

    // Back-to-back frames without an idle gap.
    send_byte(8'h00);
    send_byte(8'hFF);
    idle_bits(2);

    // Reset in the middle of data bit 4 of 0x96.
    rd = 8'h96;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rd[i]);
    u_if.iRx = rd[4];
    repeat (N / 2) @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    check("midreset_busy", int'(u_if.oBusy), 0);
    check("midreset_data", int'(u_if.oData), 0);
    check("midreset_pulses", int'({u_if.oData_Valid, u_if.oFrame_Err, u_if.oBreak, u_if.oParity_Err}), 0);
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    idle_bits(12);
    send_byte(8'hC3);
    idle_bits(2);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1.
    expect_evt(F_VALID, 8'h07, cyc + 1 + LAT);
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(2);
    expect_evt(F_PERR, 8'h07, cyc + 1 + LAT);
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(2);
`endif

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 10 * N) begin
      @(negedge iClk);
      wait_cnt++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
